// File: rtl/step_counter_ctl_pkg.sv
// Shared encodings for the step counter: count direction and overflow mode.
package step_counter_ctl_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-value logic for one enabled step: wrap/saturate
// arithmetic, overflow event and terminal (bound reached) event.
module step_counter_next
    import step_counter_ctl_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] Q,
    input  logic [SIZE-1:0] Step,
    input  logic [SIZE-1:0] Limit,
    input  logic            Dir,
    input  logic            Mode,
    output logic [SIZE-1:0] Q_Next,
    output logic            Ovf_Evt,
    output logic            Term_Evt
);

    logic [SIZE:0]   sum;
    logic [SIZE:0]   diff;
    logic [SIZE-1:0] bound;

    always_comb begin
        sum     = {1'b0, Q} + {1'b0, Step};
        diff    = {1'b0, Q} - {1'b0, Step};
        Q_Next  = Q;
        Ovf_Evt = 1'b0;
        if (Dir == DIR_UP) begin
            // A Q already above Limit also lands here, so it clamps down to Limit.
            if (Mode == MODE_SAT && sum > {1'b0, Limit}) begin
                Q_Next  = Limit;
                Ovf_Evt = 1'b1;
            end else begin
                Q_Next  = sum[SIZE-1:0];
                Ovf_Evt = sum[SIZE];
            end
        end else begin
            // diff[SIZE] is the borrow: Step > Q.
            if (diff[SIZE]) begin
                Q_Next  = (Mode == MODE_WRAP) ? diff[SIZE-1:0] : '0;
                Ovf_Evt = 1'b1;
            end else begin
                Q_Next  = diff[SIZE-1:0];
            end
        end
        bound    = (Dir == DIR_DOWN) ? '0 : Limit;
        Term_Evt = (Q_Next == bound);
    end

endmodule

// File: rtl/step_counter_ctl.sv
// Up/down counter with runtime step and limit, wrap or saturate mode,
// load, terminal pulse, sticky overflow and capture register.
module step_counter_ctl
    import step_counter_ctl_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [SIZE-1:0] Initial,
    input  logic            Load,
    input  logic            Enable,
    input  logic            Dir,
    input  logic [SIZE-1:0] Step,
    input  logic [SIZE-1:0] Limit,
    input  logic            Mode,
    input  logic            Capture,
    input  logic            Clear_Flags,
    output logic [SIZE-1:0] Q,
    output logic            Terminal,
    output logic            Overflow,
    output logic [SIZE-1:0] Q_Hold
);

    logic [SIZE-1:0] q_q, q_d;
    logic            term_q, term_d;
    logic            ovf_q, ovf_d;
    logic [SIZE-1:0] hold_q;

    logic [SIZE-1:0] step_q_next;
    logic            step_ovf;
    logic            step_term;
    logic            stepping;

    step_counter_next #(.SIZE(SIZE)) u_next (
        .Q        (q_q),
        .Step     (Step),
        .Limit    (Limit),
        .Dir      (Dir),
        .Mode     (Mode),
        .Q_Next   (step_q_next),
        .Ovf_Evt  (step_ovf),
        .Term_Evt (step_term)
    );

    assign stepping = Enable && !Load;

    always_comb begin
        q_d    = q_q;
        term_d = 1'b0;
        ovf_d  = Clear_Flags ? 1'b0 : ovf_q;
        if (Load) begin
            q_d = Initial;
        end else if (Enable) begin
            q_d    = step_q_next;
            term_d = step_term;
        end
        // A new overflow event beats a same-cycle clear.
        if (stepping && step_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_q    <= Initial;
            term_q <= 1'b0;
            ovf_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            q_q    <= q_d;
            term_q <= term_d;
            ovf_q  <= ovf_d;
            if (Capture) begin
                hold_q <= q_q;
            end
        end
    end

    assign Q        = q_q;
    assign Terminal = term_q;
    assign Overflow = ovf_q;
    assign Q_Hold   = hold_q;

endmodule

// File: doc/step_counter_ctl.md
Name: step_counter_ctl

Overview:
Parametrised up/down counter with a runtime step, a programmable upper limit, and a wrap or saturate mode. It also provides a synchronous load, a registered terminal-count pulse, a sticky overflow flag and a capture (hold) register. It is the general-purpose address and sequence counter for the datapath and replaces fixed-step counters. Single clock domain.

Parameters:
SIZE, 16, width of counter, step, limit and hold register

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Initial  in  SIZE  value loaded into Q on Reset and on Load
Load  in  1  synchronous reload of Q from Initial
Enable  in  1  advance Q by Step this cycle
Dir  in  1  1 = count up, 0 = count down
Step  in  SIZE  unsigned increment/decrement magnitude
Limit  in  SIZE  upper bound (saturate clamp and up-terminal value)
Mode  in  1  0 = wrap (modulo 2^SIZE), 1 = saturate
Capture  in  1  copy current Q into Q_Hold
Clear_Flags  in  1  clear Overflow
Q  out  SIZE  counter value (registered)
Terminal  out  1  one-cycle pulse, registered
Overflow  out  1  sticky overflow/underflow flag, registered
Q_Hold  out  SIZE  captured counter value, registered

Behaviour:
- Reset (sync, active-high; clock Clock): Q <= Initial, Terminal <= 0, Overflow <= 0, Q_Hold <= 0. Reset overrides every other input.
- Q priority per edge is Reset > Load > Enable > hold.
  - Load: Q <= Initial, Terminal <= 0, Overflow unchanged.
- Enabled step arithmetic uses SIZE+1 bits:
  - Up: sum = Q + Step.
  - Down: diff = Q - Step.
- Wrap mode (Mode=0):
  - Q <= sum[SIZE-1:0] or diff[SIZE-1:0].
  - Overflow is set on carry out (up) or borrow (down).
  - Limit is ignored except for Terminal.
- Saturate mode (Mode=1):
  - Up: if sum > Limit (including carry), Q <= Limit and Overflow is set.
  - Up with Q already above Limit: Q <= Limit (may decrease) and Overflow is set.
  - Down: if Step > Q, Q <= 0 and Overflow is set.
- Terminal:
  - Set to 1 at the edge where an enabled step produces a new Q equal to the bound (Limit when Dir=1, 0 when Dir=0); otherwise 0 next cycle.
  - This includes Step=0 when Q already equals the bound.
  - Never asserted by Load or Reset.
- Overflow:
  - Sticky until Clear_Flags.
  - A set and Clear_Flags in the same cycle leave it at 1 (set wins).
- Capture: Q_Hold <= Q (pre-update value) on any edge with Capture=1, independent of Load/Enable. Reset wins.
- Enable=0: Q, Overflow and Q_Hold hold; Terminal returns to 0.
- Latency: 1 cycle from Enable to updated Q/Terminal/Overflow. No combinational input-to-output paths.
- Dir, Mode, Step and Limit may change any cycle and are sampled only on enabled edges.

Decomposition:
- Shared package contents:
  - MODE_WRAP=1'b0, MODE_SAT=1'b1
  - DIR_DOWN=1'b0, DIR_UP=1'b1
- One combinational sub-module, step_counter_next:
  - Inputs: Q, Step, Limit, Dir, Mode.
  - Outputs: next Q, overflow event, terminal event.
- Top level holds all registers and priority logic. Q_Hold is a plain enabled register inline.

Test Plan (SIZE=8):
1. Reset with Initial=8'h10, then Enable=1, Dir=1, Step=2, Mode=0 for 3 cycles -> Q=10,12,14,16 hex; Terminal=0; Overflow=0.
2. Wrap up: Q=8'hFE, Step=3, Mode=0, Limit=8'hFF -> Q=8'h01 and Overflow=1. Next step with Step=0 leaves Q=8'h01, Overflow stays 1.
3. Saturate up: Q=8'h30, Limit=8'h35, Step=4, Mode=1 -> Q=34 then 35 with Overflow=1, Terminal pulses one cycle; further steps hold Q=35 with Terminal=1 each enabled cycle.
4. Saturate down: Q=8'h03, Step=5, Dir=0, Mode=1 -> Q=0, Overflow=1, Terminal=1 for one cycle. Clear_Flags alone then drops Overflow to 0.
5. Simultaneous events: Load=1 with Enable=1 and Initial=8'h7A -> Q=7A, Terminal=0. Reset=1 with Load=1 and Capture=1 -> Q=Initial, Q_Hold=0, flags=0. Overflow event plus Clear_Flags -> Overflow=1.
6. Capture: Q=8'h22, Enable=1, Step=1, Capture=1 -> Q_Hold=22, Q=23. Reset asserted mid-count then deasserted -> counting resumes from Initial on the first enabled edge.
